// File: rtl/systolic_pingpong_buffer.sv
// rtl/systolic_pingpong_buffer.sv - double-banked row buffer between systolic array output and consumers
// Writer fills one bank (after dropping skew rows) while the reader randomly accesses the other.
module systolic_pingpong_buffer #(
  parameter int DATAWIDTH_output = 32,
  parameter int N_SIZE           = 32,
  parameter int DEPTH            = 512,
  parameter int ADDR_WIDTH       = $clog2(DEPTH),
  parameter int SKIP_ROWS        = 31
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [ADDR_WIDTH:0]                cfg_rows,
  input  logic                               wr_valid,
  output logic                               wr_ready,
  input  logic [DATAWIDTH_output*N_SIZE-1:0] wr_data,
  input  logic                               rd_en,
  input  logic [ADDR_WIDTH-1:0]              rd_addr,
  input  logic                               rd_done,
  output logic                               rd_valid,
  output logic [DATAWIDTH_output*N_SIZE-1:0] rd_data,
  output logic                               rd_bank_ready,
  output logic [ADDR_WIDTH:0]                rd_rows,
  output logic [1:0]                         bank_full,
  output logic [2:0]                         err_flags
);

  localparam int LW     = DATAWIDTH_output * N_SIZE;
  localparam int AW1    = ADDR_WIDTH + 1;
  localparam int SKIP_W = $clog2(SKIP_ROWS + 2);
  localparam logic [AW1-1:0]    DEPTH_L = AW1'(DEPTH);
  localparam logic [SKIP_W-1:0] SKIP_L  = SKIP_W'(SKIP_ROWS);

  typedef enum logic [1:0] {ST_EMPTY, ST_FILLING, ST_FULL} bank_state_t;

  bank_state_t           state [2];
  logic [AW1-1:0]        rows_q [2];
  logic                  wb, rb, init_done;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [SKIP_W-1:0]     skip_cnt;
  logic [LW-1:0]         mem [0:1][0:DEPTH-1];

  logic [AW1-1:0] cfg_eff, rows_cur;
  logic           wr_accept, frame_start, wr_skip, wr_store, wr_last, rd_ok;

  always_comb begin
    cfg_eff       = (cfg_rows == '0 || cfg_rows > DEPTH_L) ? DEPTH_L : cfg_rows;
    wr_ready      = init_done && (state[wb] != ST_FULL);
    wr_accept     = wr_valid && wr_ready;
    frame_start   = (state[wb] == ST_EMPTY);
    // The row limit of a frame is only latched on its first accept, so use cfg directly then.
    rows_cur      = frame_start ? cfg_eff : rows_q[wb];
    wr_skip       = (skip_cnt < SKIP_L);
    wr_store      = wr_accept && !wr_skip;
    wr_last       = wr_store && ({1'b0, wr_addr} == rows_cur - 1'b1);
    rd_bank_ready = (state[rb] == ST_FULL);
    rd_rows       = rd_bank_ready ? rows_q[rb] : '0;
    rd_ok         = rd_bank_ready && ({1'b0, rd_addr} < rows_q[rb]);
    bank_full     = {state[1] == ST_FULL, state[0] == ST_FULL};
  end

  always_ff @(posedge clk) begin
    if (wr_store) mem[wb][wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state[0]  <= ST_EMPTY;
      state[1]  <= ST_EMPTY;
      rows_q[0] <= '0;
      rows_q[1] <= '0;
      wb        <= 1'b0;
      rb        <= 1'b0;
      init_done <= 1'b0;
      wr_addr   <= '0;
      skip_cnt  <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      err_flags <= '0;
    end else begin
      init_done <= 1'b1;

      if (wr_accept) begin
        if (frame_start) begin
          state[wb]  <= ST_FILLING;
          rows_q[wb] <= cfg_eff;
        end
        if (wr_skip) begin
          skip_cnt <= skip_cnt + 1'b1;
        end else if (wr_last) begin
          state[wb] <= ST_FULL;
          wb        <= ~wb;
          wr_addr   <= '0;
          skip_cnt  <= '0;
        end else begin
          wr_addr <= wr_addr + 1'b1;
        end
      end

      // Invalid reads still answer (with zero data) so consumers never wait on a lost request.
      if (rd_en) begin
        rd_valid <= 1'b1;
        if (rd_ok) begin
          rd_data <= mem[rb][rd_addr];
        end else begin
          rd_data <= '0;
          if (!rd_bank_ready) err_flags[0] <= 1'b1;
          else                err_flags[1] <= 1'b1;
        end
      end else begin
        rd_valid <= 1'b0;
      end

      // wb never equals rb while rb is FULL and wb accepts, so these state writes cannot collide.
      if (rd_done) begin
        if (rd_bank_ready) begin
          state[rb] <= ST_EMPTY;
          rb        <= ~rb;
        end else begin
          err_flags[2] <= 1'b1;
        end
      end
    end
  end

endmodule
